// File: rtl/regfile_pkg.sv
// Shared constants for the register file: reset init table and the R0 index.
// The init table is 16 entries of 16 bits; wider/narrower/deeper files adapt it via reg_init_val.
package regfile_pkg;

    localparam int INIT_N = 16;
    localparam int R0_IDX = 0;

    localparam logic [15:0] REG_INIT [INIT_N] = '{
        16'h0000, 16'h7B18, 16'h245B, 16'hFFFF,
        16'hF0FF, 16'h0051, 16'h6666, 16'h00FF,
        16'hFF88, 16'h0000, 16'h0000, 16'h3099,
        16'hCCCC, 16'h0002, 16'h0011, 16'h0000
    };

    // Entries beyond the table reset to zero.
    function automatic logic [15:0] reg_init_val(input int idx);
        logic [3:0] sel;
        sel = idx[3:0];
        if (idx < INIT_N) begin
            return REG_INIT[sel];
        end
        return 16'h0000;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Port bundle between the decode/writeback stages (master) and the register file (slave).
interface regfile_sb_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              r0_wr_en;
    logic [DATA_W-1:0] r0_data;
    logic              sb_set_en;
    logic [ADDR_W-1:0] sb_set_addr;
    logic              busy1;
    logic              busy2;
    logic [DEPTH-1:0]  busy_vec;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
               r0_wr_en, r0_data, sb_set_en, sb_set_addr,
        input  rd_data1, rd_data2, busy1, busy2, busy_vec
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
               r0_wr_en, r0_data, sb_set_en, sb_set_addr,
        output rd_data1, rd_data2, busy1, busy2, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback; a same-cycle set
// on the index being cleared wins, so back-to-back issue to one destination stays busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     set_en_i,
    input  logic [$clog2(DEPTH)-1:0] set_addr_i,
    input  logic                     clr_en_i,
    input  logic [$clog2(DEPTH)-1:0] clr_addr_i,
    input  logic                     r0_clr_i,
    output logic [DEPTH-1:0]         busy_vec_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (r0_clr_i) begin
            busy_d[R0_IDX] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, a general and a dedicated R0 write port,
// and a busy scoreboard. Optional macro REGFILE_BYPASS_EN forwards same-cycle writes/clears to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] R0_ADDR = ADDR_W'(R0_IDX);

    // Assertion is immediate; release is aligned to clk through two flops.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // R0 port is applied last so it overrides a general write to index 0.
    always_comb begin
        regs_d = regs_q;
        if (bus.wr_en) begin
            regs_d[bus.wr_addr] = bus.wr_data;
        end
        if (bus.r0_wr_en) begin
            regs_d[R0_IDX] = bus.r0_data;
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= DATA_W'(reg_init_val(i));
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic [DEPTH-1:0] busy_vec;

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk_i      (clk),
        .reset_i    (rst_int),
        .set_en_i   (bus.sb_set_en),
        .set_addr_i (bus.sb_set_addr),
        .clr_en_i   (bus.wr_en),
        .clr_addr_i (bus.wr_addr),
        .r0_clr_i   (bus.r0_wr_en),
        .busy_vec_o (busy_vec)
    );

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    assign rd_addr[0] = bus.rd_addr1;
    assign rd_addr[1] = bus.rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = busy_vec[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (!rst_int) begin
                if (bus.r0_wr_en && rd_addr[p] == R0_ADDR) begin
                    rd_data[p] = bus.r0_data;
                end else if (bus.wr_en && rd_addr[p] == bus.wr_addr) begin
                    rd_data[p] = bus.wr_data;
                end
                // A same-cycle clear reads as free unless a same-cycle issue re-marks it.
                if ((bus.wr_en && rd_addr[p] == bus.wr_addr) ||
                    (bus.r0_wr_en && rd_addr[p] == R0_ADDR)) begin
                    rd_busy[p] = bus.sb_set_en && (bus.sb_set_addr == rd_addr[p]);
                end
            end
`endif
        end
    end

    assign bus.rd_data1 = rd_data[0];
    assign bus.rd_data2 = rd_data[1];
    assign bus.busy1    = rd_busy[0];
    assign bus.busy2    = rd_busy[1];
    assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 16x16 instance plus a 32x32 instance for the init-table sweep.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_sb_if #(.DATA_W(16), .DEPTH(16)) bus   ();
    regfile_sb_if #(.DATA_W(32), .DEPTH(32)) bus_w ();

    regfile_sb #(.DATA_W(16), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    regfile_sb #(.DATA_W(32), .DEPTH(32)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 1'b0;     bus.wr_addr = '0;     bus.wr_data = '0;
        bus.r0_wr_en = 1'b0;  bus.r0_data = '0;
        bus.sb_set_en = 1'b0; bus.sb_set_addr = '0;
        bus_w.wr_en = 1'b0;   bus_w.wr_addr = '0;   bus_w.wr_data = '0;
        bus_w.r0_wr_en = 1'b0; bus_w.r0_data = '0;
        bus_w.sb_set_en = 1'b0; bus_w.sb_set_addr = '0;
    endtask

    task automatic release_reset();
        idle();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        idle();
        bus.rd_addr1 = 4'd1;   bus.rd_addr2 = 4'd8;
        bus_w.rd_addr1 = 5'd20; bus_w.rd_addr2 = 5'd1;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.rd_data1 !== 16'h7B18) begin n_bad++; $display("FAIL reset_rd1: got %h want 7b18", bus.rd_data1); end
        n_cmp++; if (bus.rd_data2 !== 16'hFF88) begin n_bad++; $display("FAIL reset_rd2: got %h want ff88", bus.rd_data2); end
        n_cmp++; if (bus.busy_vec !== 16'h0000) begin n_bad++; $display("FAIL reset_busy: got %h want 0000", bus.busy_vec); end
        // Activity during reset must be ignored, including any forwarding.
        bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 16'hDEAD;
        bus.r0_wr_en = 1'b1; bus.r0_data = 16'hBEEF;
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 4'd8;
        #1;
        n_cmp++; if (bus.rd_data1 !== 16'h7B18) begin n_bad++; $display("FAIL reset_nofwd: got %h want 7b18", bus.rd_data1); end
        repeat (3) tick();
        n_cmp++; if (bus.rd_data1 !== 16'h7B18) begin n_bad++; $display("FAIL reset_hold_rd1: got %h want 7b18", bus.rd_data1); end
        n_cmp++; if (bus.busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_hold_busy2: got %b want 0", bus.busy2); end
        release_reset();
        n_cmp++; if (bus.rd_data1 !== 16'h7B18) begin n_bad++; $display("FAIL post_reset_rd1: got %h want 7b18", bus.rd_data1); end
        n_cmp++; if (bus.busy_vec !== 16'h0000) begin n_bad++; $display("FAIL post_reset_busy: got %h want 0000", bus.busy_vec); end
    endtask

    task automatic test_write();
        bus.rd_addr1 = 4'd5;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 16'hABCD;
        #1;
        n_cmp++; if (bus.rd_data1 !== (BYP ? 16'hABCD : 16'h0051)) begin n_bad++; $display("FAIL write_same_cycle: got %h want %h", bus.rd_data1, BYP ? 16'hABCD : 16'h0051); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_data1 !== 16'hABCD) begin n_bad++; $display("FAIL write_next_cycle: got %h want abcd", bus.rd_data1); end
    endtask

    task automatic test_r0_port();
        bus.rd_addr1 = 4'd0; bus.rd_addr2 = 4'd3;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'h0BAD;
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_data1 !== 16'h0BAD) begin n_bad++; $display("FAIL r0_writable: got %h want 0bad", bus.rd_data1); end
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'h1111;
        bus.r0_wr_en = 1'b1; bus.r0_data = 16'h2222;
        #1;
        n_cmp++; if (bus.rd_data1 !== (BYP ? 16'h2222 : 16'h0BAD)) begin n_bad++; $display("FAIL collide_same_cycle: got %h want %h", bus.rd_data1, BYP ? 16'h2222 : 16'h0BAD); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_data1 !== 16'h2222) begin n_bad++; $display("FAIL collide_r0_wins: got %h want 2222", bus.rd_data1); end
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h1111;
        bus.r0_wr_en = 1'b1; bus.r0_data = 16'h3333;
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rd_data1 !== 16'h3333) begin n_bad++; $display("FAIL dual_write_r0: got %h want 3333", bus.rd_data1); end
        n_cmp++; if (bus.rd_data2 !== 16'h1111) begin n_bad++; $display("FAIL dual_write_r3: got %h want 1111", bus.rd_data2); end
    endtask

    task automatic test_scoreboard();
        bus.rd_addr1 = 4'd7; bus.rd_addr2 = 4'd6;
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 4'd7;
        #1;
        n_cmp++; if (bus.busy1 !== 1'b0) begin n_bad++; $display("FAIL set_not_visible_yet: got %b want 0", bus.busy1); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.busy_vec !== 16'h0080) begin n_bad++; $display("FAIL set_busy_vec: got %h want 0080", bus.busy_vec); end
        n_cmp++; if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b0) begin n_bad++; $display("FAIL set_busy12: got %b%b want 10", bus.busy1, bus.busy2); end
        bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h0707;
        #1;
        n_cmp++; if (bus.busy1 !== !BYP) begin n_bad++; $display("FAIL clear_same_cycle: got %b want %b", bus.busy1, !BYP); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.busy_vec !== 16'h0000) begin n_bad++; $display("FAIL clear_busy_vec: got %h want 0000", bus.busy_vec); end
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 4'd7;
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'h0777;
        #1;
        n_cmp++; if (bus.busy1 !== 1'b1) begin n_bad++; $display("FAIL set_clear_same_cycle: got %b want 1", bus.busy1); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.busy_vec !== 16'h0080) begin n_bad++; $display("FAIL set_wins_over_clear: got %h want 0080", bus.busy_vec); end
    endtask

    task automatic test_r0_busy();
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 4'd0;
        tick();
        idle();
        #1;
        n_cmp++; if (bus.busy_vec !== 16'h0081) begin n_bad++; $display("FAIL r0_set: got %h want 0081", bus.busy_vec); end
        bus.r0_wr_en = 1'b1; bus.r0_data = 16'h4444;
        tick();
        idle();
        #1;
        n_cmp++; if (bus.busy_vec !== 16'h0080) begin n_bad++; $display("FAIL r0_clear: got %h want 0080", bus.busy_vec); end
        bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 16'h9999;
        tick();
        idle();
        #1;
        n_cmp++; if (bus.busy_vec !== 16'h0080) begin n_bad++; $display("FAIL clear_idle_index: got %h want 0080", bus.busy_vec); end
    endtask

    task automatic test_wide_write();
        bus_w.wr_en = 1'b1; bus_w.wr_addr = 5'd20; bus_w.wr_data = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        n_cmp++; if (bus_w.rd_data1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wide_write_r20: got %h want deadbeef", bus_w.rd_data1); end
    endtask

    task automatic test_async_reset();
        bus.rd_addr1 = 4'd2; bus.rd_addr2 = 4'd4;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h5555;
        bus.sb_set_en = 1'b1; bus.sb_set_addr = 4'd4;
        tick();
        idle();
        for (int i = 5; i < 7; i++) begin
            bus.sb_set_en = 1'b1; bus.sb_set_addr = i[3:0];
            tick();
        end
        idle();
        #1;
        n_cmp++; if (bus.rd_data1 !== 16'h5555 || bus.busy_vec !== 16'h00F0) begin n_bad++; $display("FAIL pre_async: got %h/%h want 5555/00f0", bus.rd_data1, bus.busy_vec); end
        tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.rd_data1 !== 16'h245B) begin n_bad++; $display("FAIL async_reset_r2: got %h want 245b", bus.rd_data1); end
        n_cmp++; if (bus.busy_vec !== 16'h0000 || bus.busy2 !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy: got %h/%b want 0000/0", bus.busy_vec, bus.busy2); end
        tick();
        release_reset();
    endtask

    task automatic test_wide_reset();
        bus_w.rd_addr1 = 5'd20; bus_w.rd_addr2 = 5'd1;
        #1;
        n_cmp++; if (bus_w.rd_data1 !== 32'h0000_0000) begin n_bad++; $display("FAIL wide_r20: got %h want 00000000", bus_w.rd_data1); end
        n_cmp++; if (bus_w.rd_data2 !== 32'h0000_7B18) begin n_bad++; $display("FAIL wide_r1: got %h want 00007b18", bus_w.rd_data2); end
        bus_w.rd_addr1 = 5'd8; bus_w.rd_addr2 = 5'd15;
        #1;
        n_cmp++; if (bus_w.rd_data1 !== 32'h0000_FF88) begin n_bad++; $display("FAIL wide_r8: got %h want 0000ff88", bus_w.rd_data1); end
        n_cmp++; if (bus_w.busy_vec !== 32'h0) begin n_bad++; $display("FAIL wide_busy: got %h want 0", bus_w.busy_vec); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_r0_port();
        test_scoreboard();
        test_r0_busy();
        test_wide_write();
        test_async_reset();
        test_wide_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised, clocked register file with a per-register busy scoreboard for the pipelined CPU datapath.
- Two combinational read ports.
- One general synchronous write port.
- One dedicated R0 write port, used for the implicit R0 result of multiply/divide.
- Reset preloads a fixed init table.
- The scoreboard tracks in-flight destinations so decode can stall on read-after-write hazards.

Parameters:
DATA_W, 16, register width in bits
DEPTH, 16, number of registers; power of two, at least 2
ADDR_W, $clog2(DEPTH), index width; derived, never overridden

Ports:
clk  in  1  clock; rising edge active
reset  in  1  asynchronous, active-high reset
rd_addr1  in  ADDR_W  read port 1 index
rd_addr2  in  ADDR_W  read port 2 index
rd_data1  out  DATA_W  read port 1 data
rd_data2  out  DATA_W  read port 2 data
wr_en  in  1  general write enable
wr_addr  in  ADDR_W  general write index
wr_data  in  DATA_W  general write data
r0_wr_en  in  1  dedicated R0 write enable
r0_data  in  DATA_W  dedicated R0 write data
sb_set_en  in  1  mark destination busy (instruction issued)
sb_set_addr  in  ADDR_W  destination index to mark
busy1  out  1  busy[rd_addr1]
busy2  out  1  busy[rd_addr2]
busy_vec  out  DEPTH  full scoreboard

Behaviour:
- Clock and reset are fixed: single clock, clk. Reset is asynchronous and active-high, named reset.
- Reset (asynchronous assert, synchronous release):
  - R[i] = REG_INIT[i] for i < 16; R[i] = 0 for i >= 16.
  - For DATA_W < 16, init values are truncated; for DATA_W > 16, they are zero-extended.
  - busy_vec = 0.
  - rd_data reflects the init values combinationally while reset is held. busy1 and busy2 = 0.
- Reads: combinational, zero latency. rd_data = R[rd_addr] as stored.
- Writes: on the rising edge of clk, R[wr_addr] <= wr_data when wr_en. R0 has no hardwired-zero behaviour; it is writable.
- R0 port: on the clock edge, R[0] <= r0_data when r0_wr_en. The two write ports are independent and may fire in the same cycle.
- Collision: wr_en with wr_addr == 0 and r0_wr_en in the same cycle: r0_data wins. The general write is dropped.
- Scoreboard, per clock edge, in priority order:
  - set: busy[sb_set_addr] <= 1 when sb_set_en.
  - clear: busy[wr_addr] <= 0 when wr_en; busy[0] <= 0 when r0_wr_en.
  - Set and clear on the same index in the same cycle: set wins. This is a back-to-back issue to the same destination.
  - Clear of an index that is not busy: no effect.
  - Set of an index that is already busy: stays 1. No counting, no error.
- busy1 and busy2 are combinational from the registered busy_vec. They do not reflect same-cycle set or clear (no scoreboard bypass).
- Reset mid-operation: all registers return to init and busy clears immediately. Writes in flight are lost.
- Indices are always in range because DEPTH is a power of two. No wrap logic is needed.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding.
  - rd_dataN = r0_data if r0_wr_en and rd_addrN == 0.
  - Otherwise rd_dataN = wr_data if wr_en and rd_addrN == wr_addr.
  - Otherwise rd_dataN = R[rd_addrN].
  - The same forwarding applies to busyN: a same-cycle clear reads as 0 unless a same-cycle set targets that index.
  - Forwarding is suppressed while reset is asserted.
- Undefined: reads return stored state only. A new value is visible the cycle after the write.

Decomposition:
- Package regfile_pkg:
  - REG_INIT: 16 x 16-bit array = 0000, 7B18, 245B, FFFF, F0FF, 0051, 6666, 00FF, FF88, 0000, 0000, 3099, CCCC, 0002, 0011, 0000.
  - R0_IDX = 0.
- One sub-module: regfile_scoreboard, holding busy_vec and the set/clear priority logic, instantiated once.
- The storage array and read muxes stay in the top module.

Test Plan:
1. Assert reset, read addresses 1 and 8 -> rd_data1 = 7B18, rd_data2 = FF88, busy_vec = 0; hold through several edges with writes active -> values unchanged.
2. wr_en, wr_addr = 5, wr_data = ABCD -> next cycle read of addr 5 = ABCD. Same-cycle read = 0051 without REGFILE_BYPASS_EN, ABCD with it.
3. Same cycle: wr_en, wr_addr = 0, wr_data = 1111, and r0_wr_en with r0_data = 2222 -> R0 = 2222. Additionally, with wr_addr = 3 both writes land: R3 = 1111, R0 = 2222.
4. sb_set_en on addr 7 -> busy_vec[7] = 1 next cycle and busy1 = 1 with rd_addr1 = 7. Then wr_en on addr 7 -> busy clears. Then set and clear of addr 7 in the same cycle -> busy stays 1.
5. Set busy on addr 0, then r0_wr_en -> busy_vec[0] = 0. Then wr_en to addr 9 while addr 9 is not busy -> busy_vec unchanged.
6. Assert reset asynchronously mid-cycle after writes to R2 = 5555 with busy_vec = 00F0 -> R2 = 245B and busy_vec = 0 before the next edge. Sweep DEPTH = 32, DATA_W = 32: R20 = 0 and R1 = 00007B18 after reset.
